// File: rtl/tx_hs_pkg.sv
// ----------------------------------------------------------------------------
// tx_hs_pkg
// Shared definitions for the D-PHY HS transmit lane sequencer.
//   tx_state_e : sequencer states and their DphyTxState encodings
//   lane_op_e  : per-lane DataOut register operation, chosen by the top level
//   SYNC_BYTE  : HS sync pattern sent on every lane for one cycle
// Optional feature macro honoured by the lane logic: TX_HS_TRAIL_INVERT_EN
// ----------------------------------------------------------------------------
package tx_hs_pkg;

    typedef enum logic [2:0] {
        ST_STOP  = 3'b000,
        ST_GO    = 3'b001,
        ST_SYNC  = 3'b011,
        ST_DATA  = 3'b010,
        ST_TRAIL = 3'b110,
        ST_EXIT  = 3'b111
    } tx_state_e;

    // What each lane loads into its DataOut register at the next edge.
    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,   // repeat the current byte
        OP_ZERO  = 3'd1,   // 0x00 (STOP / GO / EXIT)
        OP_SYNC  = 3'd2,   // sync byte, also seeds the last-byte register
        OP_DATA  = 3'd3,   // accepted payload byte
        OP_TRAIL = 3'd4    // trail byte derived from the last byte
    } lane_op_e;

    localparam logic [7:0] SYNC_BYTE = 8'h1D;

endpackage

// File: rtl/tx_hs_lane.sv
// ----------------------------------------------------------------------------
// tx_hs_lane
// One HS data lane: registered output byte, last-sent-byte register and the
// trail byte generation.
// Ports:
//   clk      : byte clock
//   rst_n    : asynchronous active-low reset
//   op       : register operation for the next edge (from the sequencer)
//   data_in  : this lane's payload byte
//   data_out : registered byte to the serializer
// Macro TX_HS_TRAIL_INVERT_EN: when defined, the trail byte is the inverse of
// bit 7 of the last byte sent (0xFF / 0x00); otherwise the trail is 0x00 and
// no last-byte register is built.
// ----------------------------------------------------------------------------
module tx_hs_lane
    import tx_hs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  lane_op_e   op,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    logic [7:0] data_q;
    logic [7:0] data_d;
    logic [7:0] trail_byte;

`ifdef TX_HS_TRAIL_INVERT_EN
    logic [7:0] last_q;
    logic [7:0] last_d;

    // Seeding with the sync byte means an empty burst trails from 0x1D.
    always_comb begin
        last_d = last_q;
        if (op == OP_SYNC) begin
            last_d = SYNC_BYTE;
        end else if (op == OP_DATA) begin
            last_d = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 8'h00;
        end else begin
            last_q <= last_d;
        end
    end

    assign trail_byte = last_q[7] ? 8'h00 : 8'hFF;
`else
    assign trail_byte = 8'h00;
`endif

    always_comb begin
        data_d = data_q;
        case (op)
            OP_ZERO:  data_d = 8'h00;
            OP_SYNC:  data_d = SYNC_BYTE;
            OP_DATA:  data_d = data_in;
            OP_TRAIL: data_d = trail_byte;
            default:  data_d = data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 8'h00;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/tx_hs_lane_seq.sv
// ----------------------------------------------------------------------------
// tx_hs_lane_seq
// D-PHY HS transmit sequencer: STOP -> GO (HS-ZERO) -> SYNC -> DATA ->
// TRAIL -> EXIT -> STOP, driving NUM_LANES byte lanes.
// Ports:
//   TxDDRClk    : byte clock, all state changes on its rising edge
//   TxRst       : asynchronous active-low reset
//   TxRequestHS : burst request (rise starts a burst, fall ends DATA)
//   TxValidHS   : payload valid
//   TxDataHS    : payload, lane n on [8n+7:8n]
//   TxReadyHS   : payload accepted when high together with TxValidHS
//   DataOut     : registered byte per lane to the serializer
//   HsActive    : HS driver enable
//   DphyTxState : current state encoding
//   TxUnderflow : sticky, set when valid drops while DATA is still requested
// Macro TX_HS_TRAIL_INVERT_EN selects inverted-last-bit trail bytes.
// ----------------------------------------------------------------------------
module tx_hs_lane_seq
    import tx_hs_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int HSZERO_CYC  = 10,
    parameter int HSTRAIL_CYC = 15,
    parameter int TIMER_W     = 8
)
(
    input  logic                   TxDDRClk,
    input  logic                   TxRst,
    input  logic                   TxRequestHS,
    input  logic                   TxValidHS,
    input  logic [8*NUM_LANES-1:0] TxDataHS,
    output logic                   TxReadyHS,
    output logic [8*NUM_LANES-1:0] DataOut,
    output logic                   HsActive,
    output logic [2:0]             DphyTxState,
    output logic                   TxUnderflow
);

    localparam logic [TIMER_W-1:0] ZERO_LAST  = TIMER_W'(HSZERO_CYC - 1);
    localparam logic [TIMER_W-1:0] TRAIL_LAST = TIMER_W'(HSTRAIL_CYC - 1);

    tx_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               underflow_q, underflow_d;
    lane_op_e           lane_op;
    logic               accept;

    // Ready is purely a function of state and request so a falling request
    // refuses the byte in the same cycle.
    assign TxReadyHS = (state_q == ST_DATA) && TxRequestHS;
    assign accept    = TxReadyHS && TxValidHS;

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        underflow_d = underflow_q;
        lane_op     = OP_ZERO;

        case (state_q)
            ST_STOP:  if (TxRequestHS) state_d = ST_GO;
            ST_GO:    if (timer_q == ZERO_LAST) state_d = ST_SYNC;
            ST_SYNC:  state_d = ST_DATA;
            ST_DATA:  if (!TxRequestHS) state_d = ST_TRAIL;
            ST_TRAIL: if (timer_q == TRAIL_LAST) state_d = ST_EXIT;
            ST_EXIT:  state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase

        // Timer only runs in the timed states and restarts on every entry,
        // so it never counts past the longer of the two durations.
        if ((state_d == state_q) && ((state_q == ST_GO) || (state_q == ST_TRAIL))) begin
            timer_d = timer_q + TIMER_W'(1);
        end

        if ((state_q == ST_STOP) && (state_d == ST_GO)) begin
            underflow_d = 1'b0;
        end else if ((state_q == ST_DATA) && TxRequestHS && !TxValidHS) begin
            underflow_d = 1'b1;
        end

        // Lane registers are loaded with the value belonging to the state
        // being entered, so DataOut lines up with DphyTxState.
        case (state_d)
            ST_SYNC:  lane_op = OP_SYNC;
            ST_DATA:  lane_op = accept ? OP_DATA : OP_HOLD;
            ST_TRAIL: lane_op = OP_TRAIL;
            default:  lane_op = OP_ZERO;
        endcase
    end

    always_ff @(posedge TxDDRClk or negedge TxRst) begin
        if (!TxRst) begin
            state_q     <= ST_STOP;
            timer_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            underflow_q <= underflow_d;
        end
    end

    assign HsActive    = (state_q != ST_STOP) && (state_q != ST_EXIT);
    assign DphyTxState = state_q;
    assign TxUnderflow = underflow_q;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            tx_hs_lane u_lane (
                .clk      (TxDDRClk),
                .rst_n    (TxRst),
                .op       (lane_op),
                .data_in  (TxDataHS[8*gi +: 8]),
                .data_out (DataOut[8*gi +: 8])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tx_hs_lane_seq.sv
// ----------------------------------------------------------------------------
// tb_tx_hs_lane_seq
// Self-checking bench for tx_hs_lane_seq (NUM_LANES=2, HSZERO_CYC=10,
// HSTRAIL_CYC=15). Each burst is described by per-cycle request/valid/data
// tables; the expected output timeline is derived from the burst phase
// boundaries (GO length, SYNC, first low request in DATA, TRAIL length).
// Honours TX_HS_TRAIL_INVERT_EN for the expected trail bytes.
// ----------------------------------------------------------------------------
module tb_tx_hs_lane_seq;

    localparam int NL = 2;
    localparam int HZ = 10;
    localparam int HT = 15;
    localparam int N  = 80;
    localparam int D0 = HZ + 2;   // burst cycle of the first DATA cycle

    localparam logic [2:0] E_STOP  = 3'b000;
    localparam logic [2:0] E_GO    = 3'b001;
    localparam logic [2:0] E_SYNC  = 3'b011;
    localparam logic [2:0] E_DATA  = 3'b010;
    localparam logic [2:0] E_TRAIL = 3'b110;
    localparam logic [2:0] E_EXIT  = 3'b111;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req;
    logic            valid;
    logic [8*NL-1:0] din;
    logic            ready;
    logic [8*NL-1:0] dout;
    logic            hs_active;
    logic [2:0]      st;
    logic            underflow;

    int errors = 0;
    int checks = 0;
    bit uf_model = 1'b0;

    bit          req_arr   [N];
    bit          valid_arr [N];
    logic [15:0] data_arr  [N];

    tx_hs_lane_seq #(
        .NUM_LANES   (NL),
        .HSZERO_CYC  (HZ),
        .HSTRAIL_CYC (HT),
        .TIMER_W     (8)
    ) dut (
        .TxDDRClk    (clk),
        .TxRst       (rst_n),
        .TxRequestHS (req),
        .TxValidHS   (valid),
        .TxDataHS    (din),
        .TxReadyHS   (ready),
        .DataOut     (dout),
        .HsActive    (hs_active),
        .DphyTxState (st),
        .TxUnderflow (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] trail_of(input logic [15:0] last);
`ifdef TX_HS_TRAIL_INVERT_EN
        for (int l = 0; l < NL; l++) begin
            trail_of[8*l +: 8] = last[8*l+7] ? 8'h00 : 8'hFF;
        end
`else
        trail_of = last & 16'h0000;
`endif
    endfunction

    // Build one burst's stimulus. Cycle 0 is the STOP cycle with request high.
    task automatic fill(input int req_len, input bit glitch, input bit rearm, input int vprob);
        int drop;
        drop = (req_len > D0) ? req_len : D0;
        for (int c = 0; c < N; c++) begin
            data_arr[c]  = 16'($urandom);
            valid_arr[c] = ($urandom_range(0, 99) < vprob);
            if (c == 0)
                req_arr[c] = 1'b1;
            else if (glitch && c < D0)
                req_arr[c] = 1'($urandom_range(0, 1));
            else
                req_arr[c] = (c < req_len);
            if (rearm && c > drop + 3)
                req_arr[c] = 1'b1;
        end
    endtask

    // Drive one burst and compare every cycle against the phase timeline.
    // continuing=1: cycle 0 is the STOP cycle already driven and checked by
    // the previous burst.
    task automatic run_burst(input bit continuing, input string tag);
        int          drop;
        int          s;
        logic [15:0] lastb;
        bit          uf;
        logic [2:0]  e_st;
        logic [15:0] e_do;
        bit          e_rdy;
        bit          e_hs;
        int          n_acc;

        drop = -1;
        for (int c = D0; c < N; c++) begin
            if (!req_arr[c] && drop < 0) drop = c;
        end
        if (drop < 0 || drop + HT + 2 >= N) begin
            errors++;
            checks++;
            $display("FAIL %s setup drop=%0d required within table", tag, drop);
            return;
        end
        s     = drop + HT + 2;
        lastb = 16'h1D1D;
        uf    = uf_model;
        n_acc = 0;

        for (int c = (continuing ? 1 : 0); c <= s; c++) begin
            @(posedge clk);
            #1;
            req   = req_arr[c];
            valid = valid_arr[c];
            din   = data_arr[c];

            if (c == 0)                 e_st = E_STOP;
            else if (c <= HZ)           e_st = E_GO;
            else if (c == HZ + 1)       e_st = E_SYNC;
            else if (c <= drop)         e_st = E_DATA;
            else if (c <= drop + HT)    e_st = E_TRAIL;
            else if (c == drop + HT + 1) e_st = E_EXIT;
            else                        e_st = E_STOP;

            case (e_st)
                E_SYNC:  e_do = 16'h1D1D;
                E_DATA:  e_do = lastb;
                E_TRAIL: e_do = trail_of(lastb);
                default: e_do = 16'h0000;
            endcase
            e_rdy = (e_st == E_DATA) && (c < drop);
            e_hs  = (c >= 1) && (c <= drop + HT);

            @(negedge clk);
            checks += 5;
            if (st !== e_st) begin
                errors++;
                $display("FAIL %s state cyc=%0d got=%b exp=%b", tag, c, st, e_st);
            end
            if (dout !== e_do) begin
                errors++;
                $display("FAIL %s dataout cyc=%0d got=%h exp=%h", tag, c, dout, e_do);
            end
            if (ready !== e_rdy) begin
                errors++;
                $display("FAIL %s ready cyc=%0d got=%b exp=%b", tag, c, ready, e_rdy);
            end
            if (hs_active !== e_hs) begin
                errors++;
                $display("FAIL %s hsactive cyc=%0d got=%b exp=%b", tag, c, hs_active, e_hs);
            end
            if (underflow !== uf) begin
                errors++;
                $display("FAIL %s underflow cyc=%0d got=%b exp=%b", tag, c, underflow, uf);
            end

            // Effects that become visible from the next cycle on.
            if (c == 0) uf = 1'b0;
            if (e_st == E_DATA && c < drop) begin
                if (valid_arr[c]) begin
                    lastb = data_arr[c];
                    n_acc++;
                end else begin
                    uf = 1'b1;
                end
            end
        end
        uf_model = uf;
        $display("burst %s: data_cycles=%0d accepted=%0d last=%h underflow=%0d",
                 tag, drop - D0 + 1, n_acc, lastb, uf);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = 1'b0;
        valid = 1'b0;
        din   = '0;
        #2;
        checks += 5;
        if (st !== E_STOP)      begin errors++; $display("FAIL reset state got=%b exp=%b", st, E_STOP); end
        if (dout !== 16'h0000)  begin errors++; $display("FAIL reset dataout got=%h exp=0000", dout); end
        if (hs_active !== 1'b0) begin errors++; $display("FAIL reset hsactive got=%b exp=0", hs_active); end
        if (ready !== 1'b0)     begin errors++; $display("FAIL reset ready got=%b exp=0", ready); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL reset underflow got=%b exp=0", underflow); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        uf_model = 1'b0;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_basic;
        fill(D0 + 2, 1'b0, 1'b0, 100);
        data_arr[D0]     = 16'h1234;
        data_arr[D0 + 1] = 16'h5678;
        run_burst(1'b0, "basic");
    endtask

    task automatic test_trail_invert;
        fill(D0 + 1, 1'b0, 1'b0, 100);
        data_arr[D0] = 16'h8001;
        run_burst(1'b0, "trail_8001");
    endtask

    task automatic test_underflow;
        fill(D0 + 8, 1'b0, 1'b0, 100);
        valid_arr[D0 + 2] = 1'b0;
        valid_arr[D0 + 3] = 1'b0;
        valid_arr[D0 + 4] = 1'b0;
        run_burst(1'b0, "underflow");
        // Flag must still read 1 in STOP and clear once the next GO starts.
        fill(D0 + 3, 1'b0, 1'b0, 100);
        run_burst(1'b0, "after_underflow");
    endtask

    task automatic test_short_pulse;
        fill(2, 1'b0, 1'b0, 100);
        run_burst(1'b0, "pulse2");
    endtask

    task automatic test_random;
        for (int k = 0; k < 6; k++) begin
            fill($urandom_range(1, 26), 1'($urandom_range(0, 1)), 1'b0, $urandom_range(30, 100));
            run_burst(1'b0, $sformatf("random%0d", k));
        end
    endtask

    task automatic test_reset_mid;
        fill(30, 1'b0, 1'b0, 100);
        for (int c = 0; c <= D0 + 3; c++) begin
            @(posedge clk);
            #1;
            req   = req_arr[c];
            valid = valid_arr[c];
            din   = data_arr[c];
        end
        @(negedge clk);
        checks++;
        if (st !== E_DATA) begin errors++; $display("FAIL midrst pre_state got=%b exp=%b", st, E_DATA); end
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (st !== E_STOP)      begin errors++; $display("FAIL midrst state got=%b exp=%b", st, E_STOP); end
        if (dout !== 16'h0000)  begin errors++; $display("FAIL midrst dataout got=%h exp=0000", dout); end
        if (hs_active !== 1'b0) begin errors++; $display("FAIL midrst hsactive got=%b exp=0", hs_active); end
        if (ready !== 1'b0)     begin errors++; $display("FAIL midrst ready got=%b exp=0", ready); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL midrst underflow got=%b exp=0", underflow); end
        @(posedge clk);
        #1;
        checks++;
        if (st !== E_STOP) begin errors++; $display("FAIL midrst held_state got=%b exp=%b", st, E_STOP); end
        @(negedge clk);
        req      = 1'b0;
        rst_n    = 1'b1;
        uf_model = 1'b0;
        $display("reset mid-DATA: outputs forced idle");
        fill(D0 + 4, 1'b0, 1'b0, 70);
        run_burst(1'b0, "after_midrst");
    endtask

    task automatic test_back_to_back;
        fill(D0 + 3, 1'b0, 1'b1, 80);
        run_burst(1'b0, "b2b_first");
        fill(D0 + 2, 1'b0, 1'b0, 80);
        run_burst(1'b1, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trail_invert();
        test_underflow();
        test_short_pulse();
        test_random();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
